// File: rtl/sdram_init_sequencer.sv
// sdram_init_sequencer
//
// Purpose: issues the SDR SDRAM power-up command sequence once the upstream
// power-up delay stage releases sdram_init_n. The order is PRECHARGE ALL,
// REFRESH_COUNT x AUTO REFRESH, then LOAD MODE REGISTER. After that it raises
// init_done and holds it.
//
// The command, address and status outputs are registered. A command occupies
// exactly one cycle, and every other cycle drives NOP (or INHIBIT while idle).
// If sdram_init_n drops at any point after the sequence has started, the
// sequence stops and the block returns to ARMED to wait for the next rising edge.
//
// Handshake: there is no valid/ready pair. sdram_init_n is a level input. Low
// means wait, and a sampled high in ARMED starts the sequence. init_done is a
// level output that stays valid until sdram_init_n drops or reset is applied.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   sdram_init_n  in   power-up delay pulse (low = wait, rise = start)
//   sdram_cke     out  SDRAM clock enable
//   sdram_cs_n    out  chip select (active low)
//   sdram_ras_n   out  row address strobe (active low)
//   sdram_cas_n   out  column address strobe (active low)
//   sdram_we_n    out  write enable (active low)
//   sdram_addr    out  address bus [ADDR_W]
//   sdram_ba      out  bank address [BA_W]
//   busy          out  sequence in progress
//   init_done     out  initialisation complete, controller may take the bus
module sdram_init_sequencer #(
    parameter real                CLK           = 111857000.0,
    parameter int                 ADDR_W        = 11,
    parameter int                 BA_W          = 2,
    parameter int                 T_RP_NS       = 18,
    parameter int                 T_RC_NS       = 63,
    parameter int                 T_MRD_CYC     = 2,
    parameter int                 REFRESH_COUNT = 8,
    parameter logic [ADDR_W-1:0]  MODE_REG      = 11'b000_0_00_010_0_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sdram_init_n,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic              busy,
    output logic              init_done
);

    // ns -> cycles, rounded up. $rtoi truncates, so add one whenever a
    // fractional part remains. The result is clamped to at least one cycle.
    localparam real T_RP_REAL  = real'(T_RP_NS) * CLK / 1.0e9;
    localparam real T_RC_REAL  = real'(T_RC_NS) * CLK / 1.0e9;
    localparam int  T_RP_TRUNC = $rtoi(T_RP_REAL);
    localparam int  T_RC_TRUNC = $rtoi(T_RC_REAL);
    localparam int  T_RP_CEIL  = (real'(T_RP_TRUNC) < T_RP_REAL) ? T_RP_TRUNC + 1 : T_RP_TRUNC;
    localparam int  T_RC_CEIL  = (real'(T_RC_TRUNC) < T_RC_REAL) ? T_RC_TRUNC + 1 : T_RC_TRUNC;
    localparam int  T_RP_CYC   = (T_RP_CEIL < 1) ? 1 : T_RP_CEIL;
    localparam int  T_RC_CYC   = (T_RC_CEIL < 1) ? 1 : T_RC_CEIL;
    localparam int  T_MRD_USE  = (T_MRD_CYC < 1) ? 1 : T_MRD_CYC;

    localparam int  MAX_A      = (T_RP_CYC > T_RC_CYC) ? T_RP_CYC : T_RC_CYC;
    localparam int  MAX_CYC    = (MAX_A > T_MRD_USE) ? MAX_A : T_MRD_USE;
    localparam int  CNT_W      = $clog2(MAX_CYC) + 1;

    // The wait counter is loaded with (cycles - 1) when a command issues. The
    // next command issues on the edge where the counter is already zero.
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP_CYC - 1);
    localparam logic [CNT_W-1:0] RC_LOAD  = CNT_W'(T_RC_CYC - 1);
    localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'(T_MRD_USE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       REF_LAST = 4'(REFRESH_COUNT);

    // The address for PRECHARGE ALL has only A10 set.
    localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << 10;

    // Each command is packed as {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    // In PRECHARGE, REFRESH and LMR the named command has already been issued.
    // The state then waits out that command's timing before the next one.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARMED     = 3'd1;
    localparam logic [2:0] S_PRECHARGE = 3'd2;
    localparam logic [2:0] S_REFRESH   = 3'd3;
    localparam logic [2:0] S_LMR       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [3:0]        r_ref_cnt;
    logic              r_cke;
    logic [3:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [BA_W-1:0]   r_ba;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_ref_cnt <= '0;
            r_cke     <= 1'b0;
            r_cmd     <= CMD_INHIBIT;
            r_addr    <= '0;
            r_ba      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Every cycle defaults to NOP with a zero address. This keeps each
            // real command to exactly one cycle.
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_ba   <= '0;

            case (r_state)
                S_IDLE: begin
                    // A high level here is ignored. The block must see low first.
                    r_cmd <= CMD_INHIBIT;
                    if (!sdram_init_n) begin
                        r_state <= S_ARMED;
                        r_cke   <= 1'b1;
                        r_cmd   <= CMD_NOP;
                    end
                end

                S_ARMED: begin
                    if (sdram_init_n) begin
                        r_state   <= S_PRECHARGE;
                        r_cmd     <= CMD_PRE;
                        r_addr    <= PRE_ADDR;
                        r_wait    <= RP_LOAD;
                        r_ref_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                default: begin
                    if (!sdram_init_n) begin
                        // Abort: the NOP default above means no partial
                        // command can go out.
                        r_state   <= S_ARMED;
                        r_wait    <= '0;
                        r_ref_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                    end else if (r_wait != '0) begin
                        r_wait <= r_wait - CNT_ONE;
                    end else if (r_state == S_LMR) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == S_REFRESH && r_ref_cnt == REF_LAST) begin
                        r_state <= S_LMR;
                        r_cmd   <= CMD_LMR;
                        r_addr  <= MODE_REG;
                        r_wait  <= MRD_LOAD;
                    end else begin
                        // This branch covers the first refresh after
                        // PRECHARGE and each following refresh.
                        r_state   <= S_REFRESH;
                        r_cmd     <= CMD_REF;
                        r_wait    <= RC_LOAD;
                        r_ref_cnt <= r_ref_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    assign sdram_cke   = r_cke;
    assign sdram_cs_n  = r_cmd[3];
    assign sdram_ras_n = r_cmd[2];
    assign sdram_cas_n = r_cmd[1];
    assign sdram_we_n  = r_cmd[0];
    assign sdram_addr  = r_addr;
    assign sdram_ba    = r_ba;
    assign busy        = r_busy;
    assign init_done   = r_done;

endmodule

// File: doc/sdram_init_sequencer.md
Name: sdram_init_sequencer

Overview:
- Sits directly downstream of the SDRAM power-up delay stage. Consumes its `sdram_init_n` pulse: low during the power-up wait, then a rising edge.
- On the rising edge, issues the JEDEC SDR SDRAM initialisation command sequence to the chip: PRECHARGE ALL, N× AUTO REFRESH, LOAD MODE REGISTER.
- Then flags `init_done` to the memory controller / tester core.
- All command and timing generation is internal. Outputs are registered and drive the SDRAM command pins through the controller mux.

Parameters:
- CLK, 111857000.0, clock frequency in Hz (real); used to derive cycle counts.
- ADDR_W, 11, SDRAM address bus width.
- BA_W, 2, bank address width.
- T_RP_NS, 18, precharge period in ns. T_RP_CYC = ceil(T_RP_NS*CLK/1e9); equals 3 at the default CLK.
- T_RC_NS, 63, refresh cycle time in ns. T_RC_CYC = ceil(T_RC_NS*CLK/1e9); equals 8 at the default CLK.
- T_MRD_CYC, 2, cycles from LOAD MODE REGISTER to first legal command.
- REFRESH_COUNT, 8, number of AUTO REFRESH commands; legal range 2..15.
- MODE_REG, 11'b000_0_00_010_0_000, value placed on addr for LMR: burst length 1, sequential, CAS latency 2, write burst enabled.

Ports:
- clk  in  1  system clock; same domain as the delay stage.
- reset_n  in  1  asynchronous, active-low reset.
- sdram_init_n  in  1  from the delay stage. Low = power-up wait; rising edge starts the sequence. Synchronous to clk.
- sdram_cke  out  1  clock enable.
- sdram_cs_n  out  1  chip select.
- sdram_ras_n  out  1  row address strobe.
- sdram_cas_n  out  1  column address strobe.
- sdram_we_n  out  1  write enable.
- sdram_addr  out  ADDR_W  address.
- sdram_ba  out  BA_W  bank address.
- busy  out  1  sequence in progress.
- init_done  out  1  initialisation complete; controller may take the bus.

Behaviour:
- Reset (async assert, sync release): state IDLE; cke=0; command INHIBIT (cs_n=1, ras_n=cas_n=we_n=1); addr=0; ba=0; busy=0; init_done=0; counters 0.
- Commands (cs,ras,cas,we active-low):
  - NOP = 0,1,1,1.
  - PRECHARGE ALL = 0,0,1,0 with addr[10]=1, other addr bits 0.
  - AUTO REFRESH = 0,0,0,1.
  - LMR = 0,0,0,0 with addr=MODE_REG, ba=0.
  - Every command lasts exactly one cycle. All other cycles drive NOP with addr=0, ba=0.
- FSM states and transitions:
  - IDLE: INHIBIT, cke=0. On sdram_init_n=0 → ARMED.
  - ARMED: cke=1, NOP. Stays while sdram_init_n=0. When sdram_init_n=1 is sampled → PRECHARGE; the PRECHARGE command is visible the cycle after that edge (call it t0).
  - PRECHARGE: issue PRECHARGE ALL at t0, then wait → REFRESH. First REFRESH at t0+T_RP_CYC.
  - REFRESH: issue AUTO REFRESH; successive REFRESH commands are spaced T_RC_CYC apart. 4-bit refresh counter; after REFRESH_COUNT refreshes → LMR, issued T_RC_CYC after the last refresh.
  - LMR: issue LOAD MODE REGISTER, then wait T_MRD_CYC → DONE.
  - DONE: init_done=1, busy=0, NOP, cke=1. Held indefinitely.
- Defaults give this timeline: PRECHARGE t0; REFRESH at t0+3, +11, +19, +27, +35, +43, +51, +59; LMR at t0+67; init_done rises at t0+69.
- busy=1 from t0 through the last cycle before init_done rises. Otherwise 0.
- Wait counter: width = clog2(max(T_RP_CYC, T_RC_CYC, T_MRD_CYC))+1. Loaded with (cycles−1) at command issue, decrements to 0. No wrap is allowed.
- Abort: sdram_init_n=0 in any state from PRECHARGE through DONE → ARMED on the next edge.
  - busy and init_done clear that edge.
  - Next cycle is NOP; no partial command is ever emitted.
  - Refresh counter is cleared.
- sdram_init_n=1 while in IDLE is ignored: the sequence requires a low-then-high transition.
- A sdram_init_n glitch high for one cycle in ARMED starts the sequence; an immediate drop then aborts per the Abort rule.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous). cke drops to 0.

Test Plan:
- Reset, hold sdram_init_n=1 for 50 cycles → cke=0, INHIBIT throughout, init_done=0, busy=0.
- sdram_init_n low 20 cycles then high → cke=1 from ARMED entry; PRECHARGE (addr=0x400) at t0; 8 REFRESH at t0+3+8k (k=0..7); LMR addr=0x020, ba=0 at t0+67; init_done=1 at t0+69 and held; NOP on all other cycles.
- Pull sdram_init_n low at t0+30 (mid refresh) → next cycle NOP, busy=0, no further REFRESH. Raising it again restarts from PRECHARGE with exactly 8 fresh refreshes.
- After DONE, pulse sdram_init_n low for 5 cycles → init_done clears, full sequence reruns, init_done returns at t0'+69.
- Assert reset_n at t0+10 → outputs asynchronously return to INHIBIT, cke=0, busy=0 before the next clk edge.
- Override CLK=50e6, REFRESH_COUNT=2 → T_RP_CYC=1, T_RC_CYC=4; REFRESH at t0+1 and t0+5, LMR at t0+9, init_done at t0+11.
